// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - issue/writeback stage around the combinational ALU with 8-entry regfile
module alu_operand_stage #(
    parameter int WORD_SIZE = 18,
    parameter int REG_COUNT = 8,
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [IDX_W-1:0]     in_dst,
    input  logic [IDX_W-1:0]     in_src0,
    input  logic [IDX_W-1:0]     in_src1,
    input  logic                 in_imm_en,
    input  logic [WORD_SIZE-1:0] in_imm,
    output logic [WORD_SIZE-1:0] alu_r0,
    output logic [WORD_SIZE-1:0] alu_r1,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_res,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [IDX_W-1:0]     wb_dst,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 flag_z
);

    logic [WORD_SIZE-1:0] regs [REG_COUNT];
    logic                 ex_valid;
    logic                 retire;
    logic                 accept;
    logic [WORD_SIZE-1:0] fwd0;
    logic [WORD_SIZE-1:0] fwd1;

    assign retire   = ex_valid & wb_ready;
    assign in_ready = !ex_valid | wb_ready;
    assign accept   = in_valid & in_ready;
    assign wb_valid = ex_valid;
    assign wb_data  = alu_res;

    // Operand read with same-cycle bypass of the result retiring on this edge
    always_comb begin
        fwd0 = regs[in_src0];
        fwd1 = regs[in_src1];
        if (retire && (wb_dst == in_src0)) begin
            fwd0 = alu_res;
        end
        if (retire && (wb_dst == in_src1)) begin
            fwd1 = alu_res;
        end
    end

    // EX pipeline register: loads on accept, empties on retire, holds under backpressure
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid <= 1'b0;
            alu_r0   <= '0;
            alu_r1   <= '0;
            alu_op   <= '0;
            wb_dst   <= '0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            alu_op   <= in_op;
            wb_dst   <= in_dst;
            alu_r0   <= fwd0;
            alu_r1   <= in_imm_en ? in_imm : fwd1;
        end else if (retire) begin
            ex_valid <= 1'b0;
        end
    end

    // Register file writeback and zero flag; a reset drops any held result unwritten
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            flag_z <= 1'b0;
        end else if (retire) begin
            regs[wb_dst] <= alu_res;
            flag_z       <= (alu_res == '0);
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage with a behavioural ALU
module tb_alu_operand_stage;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [2:0]  in_dst = '0;
    logic [2:0]  in_src0 = '0;
    logic [2:0]  in_src1 = '0;
    logic        in_imm_en = 1'b0;
    logic [17:0] in_imm = '0;
    logic [17:0] alu_r0;
    logic [17:0] alu_r1;
    logic [3:0]  alu_op;
    logic [17:0] alu_res;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [2:0]  wb_dst;
    logic [17:0] wb_data;
    logic        flag_z;

    int total = 0;
    int bad = 0;

    logic [17:0] mreg [8];
    logic [20:0] sb [$];

    always #5 clock = ~clock;

    alu_operand_stage dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_dst    (in_dst),
        .in_src0   (in_src0),
        .in_src1   (in_src1),
        .in_imm_en (in_imm_en),
        .in_imm    (in_imm),
        .alu_r0    (alu_r0),
        .alu_r1    (alu_r1),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .flag_z    (flag_z)
    );

    // behavioural ALU closing the loop
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_res = alu_r0 + alu_r1;
            OP_SUB:  alu_res = alu_r0 - alu_r1;
            OP_XOR:  alu_res = alu_r0 ^ alu_r1;
            OP_AND:  alu_res = alu_r0 & alu_r1;
            default: alu_res = '0;
        endcase
    end

    // retire monitor: every retire must match the oldest expected result
    always @(negedge clock) begin
        logic [20:0] e;
        if (!reset && wb_valid && wb_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got dst=%0d data=%h, required no retire", wb_dst, wb_data);
            end else begin
                e = sb.pop_front();
                if ({wb_dst, wb_data} !== e) begin
                    bad++;
                    $display("FAIL retire_result: got dst=%0d data=%h, required dst=%0d data=%h",
                             wb_dst, wb_data, e[20:18], e[17:0]);
                end
            end
        end
    end

    task automatic model_push(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s0,
                              input logic [2:0] s1, input bit ie, input logic [17:0] imm);
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] r;
        a = mreg[s0];
        b = ie ? imm : mreg[s1];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            default: r = '0;
        endcase
        mreg[dst] = r;
        sb.push_back({dst, r});
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s0,
                         input logic [2:0] s1, input bit ie, input logic [17:0] imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_dst    = dst;
        in_src0   = s0;
        in_src1   = s1;
        in_imm_en = ie;
        in_imm    = imm;
    endtask

    // entered and left at posedge+1; waited = stall cycles before acceptance
    task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s0,
                         input logic [2:0] s1, input bit ie, input logic [17:0] imm, output int waited);
        bit done;
        done = 0;
        waited = 0;
        drive(op, dst, s0, s1, ie, imm);
        while (!done && waited < 50) begin
            @(negedge clock);
            if (in_ready) begin
                model_push(op, dst, s0, s1, ie, imm);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, required 1", waited);
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while ((sb.size() != 0 || wb_valid) && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (sb.size() != 0 || wb_valid) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d wb_valid=%b, required 0 0", sb.size(), wb_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int w;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if ({wb_valid, alu_r0, alu_r1, alu_op, wb_dst, flag_z} !== '0) begin
            bad++;
            $display("FAIL reset_state: got v=%b r0=%h r1=%h op=%h dst=%0d z=%b, required all 0",
                     wb_valid, alu_r0, alu_r1, alu_op, wb_dst, flag_z);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        wb_ready = 1'b0;
        issue(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 18'd9, w);
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_before_reset: got wb_valid=%b in_ready=%b, required 1 0", wb_valid, in_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        @(negedge clock);
        total++;
        if (wb_valid !== 1'b0 || flag_z !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold: got wb_valid=%b flag_z=%b, required 0 0", wb_valid, flag_z);
        end
        @(posedge clock);
        #1;
        wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            issue(OP_ADD, 3'(k), 3'(k), 3'(k), 1'b0, 18'd0, w);
        end
        drain();
    endtask

    task automatic test_imm_load();
        int w;
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 18'd5, w);
        drain();
        total++;
        if (flag_z !== 1'b0) begin
            bad++;
            $display("FAIL imm_flag_z: got %b, required 0", flag_z);
        end
        issue(OP_ADD, 3'd7, 3'd1, 3'd0, 1'b1, 18'd0, w);
        drain();
    endtask

    task automatic test_back_to_back();
        int w0;
        int w1;
        issue(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 18'd3, w0);
        issue(OP_SUB, 3'd3, 3'd2, 3'd1, 1'b0, 18'd0, w1);
        total++;
        if (w0 != 0 || w1 != 0) begin
            bad++;
            $display("FAIL back_to_back_bubble: got stalls %0d %0d, required 0 0", w0, w1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        logic [17:0] r1v;
        r1v = mreg[1];
        wb_ready = 1'b0;
        issue(OP_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 18'd1, w);
        drive(OP_SUB, 3'd7, 3'd6, 3'd1, 1'b0, 18'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++;
            if (in_ready !== 1'b0 || wb_valid !== 1'b1 || alu_r0 !== r1v || alu_r1 !== 18'd1 ||
                alu_op !== OP_ADD || wb_dst !== 3'd6 || wb_data !== r1v + 18'd1) begin
                bad++;
                $display("FAIL backpressure_hold: got rdy=%b v=%b r0=%h r1=%h op=%h dst=%0d data=%h, required 0 1 %h 1 0 6 %h",
                         in_ready, wb_valid, alu_r0, alu_r1, alu_op, wb_dst, wb_data, r1v, r1v + 18'd1);
            end
            @(posedge clock);
            #1;
        end
        wb_ready = 1'b1;
        @(negedge clock);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: got in_ready=%b, required 1", in_ready);
        end
        model_push(OP_SUB, 3'd7, 3'd6, 3'd1, 1'b0, 18'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        total++;
        if (wb_valid !== 1'b1 || wb_dst !== 3'd7) begin
            bad++;
            $display("FAIL backpressure_next: got wb_valid=%b wb_dst=%0d, required 1 7", wb_valid, wb_dst);
        end
        @(posedge clock);
        #1;
        drain();
    endtask

    task automatic test_wrap();
        int w;
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 18'h3FFFF, w);
        issue(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 18'd1, w);
        drain();
        total++;
        if (flag_z !== 1'b1) begin
            bad++;
            $display("FAIL wrap_flag_z_set: got %b, required 1", flag_z);
        end
        issue(OP_SUB, 3'd3, 3'd0, 3'd0, 1'b1, 18'd1, w);
        drain();
        total++;
        if (flag_z !== 1'b0) begin
            bad++;
            $display("FAIL wrap_flag_z_clear: got %b, required 0", flag_z);
        end
    endtask

    task automatic test_self_overwrite();
        int w;
        issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 18'd7, w);
        drain();
        total++;
        if (flag_z !== 1'b0) begin
            bad++;
            $display("FAIL self_pre_flag_z: got %b, required 0", flag_z);
        end
        issue(OP_XOR, 3'd4, 3'd4, 3'd4, 1'b0, 18'd0, w);
        drain();
        total++;
        if (flag_z !== 1'b1) begin
            bad++;
            $display("FAIL self_flag_z: got %b, required 1", flag_z);
        end
        issue(OP_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 18'd0, w);
        issue(OP_AND, 3'd6, 3'd3, 3'd3, 1'b0, 18'd0, w);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        test_reset();
        test_imm_load();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_self_overwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
